// File: rtl/common_pkg.sv
// ============================================================================
// common : shared scalar word types
// Revision: 1.0
// ============================================================================
`default_nettype none

package common;
  typedef logic [31:0] word_t;
  typedef logic [5:0]  u6;
  typedef logic [15:0] u16;
  typedef logic [25:0] u26;
endpackage

`default_nettype wire

// File: rtl/pipes_pkg.sv
// ============================================================================
// pipes : opcode constants, instruction classes and decoded-field struct
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipes;
  import common::*;

  localparam u6 OP_SPECIAL = 6'h00;
  localparam u6 OP_REGIMM  = 6'h01;
  localparam u6 OP_J       = 6'h02;
  localparam u6 OP_JAL     = 6'h03;
  localparam u6 OP_BEQ     = 6'h04;
  localparam u6 OP_BGTZ    = 6'h07;
  localparam u6 OP_ADDI    = 6'h08;
  localparam u6 OP_LUI     = 6'h0F;
  localparam u6 OP_LB      = 6'h20;
  localparam u6 OP_LHU     = 6'h25;
  localparam u6 OP_SB      = 6'h28;
  localparam u6 OP_SW      = 6'h2B;

  typedef enum logic [2:0] {
    CLS_ALU_R  = 3'd0,
    CLS_ALU_I  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_OTHER  = 3'd6
  } decode_class_t;

  typedef struct packed {
    u6             op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    u6             func;
    word_t         jump_target;
    decode_class_t cls;
  } decoded_t;

  function automatic decode_class_t classify(input u6 op);
    decode_class_t c;
    c = CLS_OTHER;
    if (op == OP_SPECIAL)                        c = CLS_ALU_R;
    else if (op >= OP_ADDI && op <= OP_LUI)      c = CLS_ALU_I;
    else if (op >= OP_LB && op <= OP_LHU)        c = CLS_LOAD;
    else if (op >= OP_SB && op <= OP_SW)         c = CLS_STORE;
    else if (op == OP_REGIMM || (op >= OP_BEQ && op <= OP_BGTZ)) c = CLS_BRANCH;
    else if (op == OP_J || op == OP_JAL)         c = CLS_JUMP;
    return c;
  endfunction

  // Function codes with a defined meaning under the SPECIAL opcode.
  function automatic logic special_func_legal(input u6 func);
    logic ok;
    ok = 1'b0;
    case (func)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
      6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction
endpackage

`default_nettype wire

// File: rtl/decode_buffer_fields.sv
// ============================================================================
// decode_fields : combinational field extraction and classification
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_fields
  import common::*;
  import pipes::*;
#(
  parameter int IMM_W = 32
) (
  input  word_t            instr,
  input  word_t            pc,
  output decoded_t         fields,
  output logic [IMM_W-1:0] imm_sext,
  output logic [IMM_W-1:0] imm_zext
);

  word_t pc_plus4;

  always_comb begin
    pc_plus4           = pc + 32'd4;
    fields.op          = instr[31:26];
    fields.rs          = instr[25:21];
    fields.rt          = instr[20:16];
    fields.rd          = instr[15:11];
    fields.func        = instr[5:0];
    // Only the region bits of pc+4 survive into the jump target.
    fields.jump_target = (pc_plus4 & 32'hF000_0000) | {4'h0, instr[25:0], 2'b00};
    fields.cls         = classify(instr[31:26]);
    imm_sext           = {{(IMM_W-16){instr[15]}}, instr[15:0]};
    imm_zext           = {{(IMM_W-16){1'b0}}, instr[15:0]};
  end

endmodule

`default_nettype wire

// File: rtl/decode_buffer.sv
// ============================================================================
// decode_buffer : circular instruction FIFO presenting a decoded head entry
// Optional out_illegal port enabled by DECODE_BUFFER_ILLEGAL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_buffer
  import common::*;
  import pipes::*;
#(
  parameter int DEPTH = 4,
  parameter int IMM_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [5:0]                 out_op,
  output logic [5:0]                 out_func,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [IMM_W-1:0]           out_imm_sext,
  output logic [IMM_W-1:0]           out_imm_zext,
  output logic [31:0]                out_jump_target,
  output logic [2:0]                 out_class,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DECODE_BUFFER_ILLEGAL_EN
  ,
  output logic                       out_illegal
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  word_t             instr_mem_q [DEPTH];
  word_t             instr_mem_d [DEPTH];
  word_t             pc_mem_q    [DEPTH];
  word_t             pc_mem_d    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  decoded_t          head;

  assign in_ready  = (count_q != FULL_COUNT) && !flush;
  assign out_valid = (count_q != '0) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = in_instr;
        pc_mem_d[wr_ptr_q]    = in_pc;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  decode_fields #(
    .IMM_W (IMM_W)
  ) u_fields (
    .instr    (instr_mem_q[rd_ptr_q]),
    .pc       (pc_mem_q[rd_ptr_q]),
    .fields   (head),
    .imm_sext (out_imm_sext),
    .imm_zext (out_imm_zext)
  );

  assign out_pc          = pc_mem_q[rd_ptr_q];
  assign out_op          = head.op;
  assign out_func        = head.func;
  assign out_rs          = head.rs;
  assign out_rt          = head.rt;
  assign out_rd          = head.rd;
  assign out_jump_target = head.jump_target;
  assign out_class       = head.cls;

`ifdef DECODE_BUFFER_ILLEGAL_EN
  assign out_illegal = (out_valid && head.cls == CLS_OTHER) ||
                       (head.op == OP_SPECIAL && !special_func_legal(head.func));
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_buffer.sv
// ============================================================================
// tb_decode_buffer : queue-model bench with directed pins and random traffic
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decode_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_jump_target, out_imm_sext, out_imm_zext;
  logic [5:0]  out_op, out_func;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [2:0]  out_class, count;

  logic        in_ready64, out_valid64;
  logic [31:0] out_pc64, out_jump_target64;
  logic [63:0] out_imm_sext64, out_imm_zext64;
  logic [5:0]  out_op64, out_func64;
  logic [4:0]  out_rs64, out_rt64, out_rd64;
  logic [2:0]  out_class64, count64;
`ifdef DECODE_BUFFER_ILLEGAL_EN
  logic        out_illegal, out_illegal64;
`endif

  int total = 0;
  int bad   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  decode_buffer #(.DEPTH(DEPTH), .IMM_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_func(out_func), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm_sext(out_imm_sext), .out_imm_zext(out_imm_zext),
    .out_jump_target(out_jump_target), .out_class(out_class), .count(count)
`ifdef DECODE_BUFFER_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );

  decode_buffer #(.DEPTH(DEPTH), .IMM_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .out_op(out_op64), .out_func(out_func64), .out_rs(out_rs64), .out_rt(out_rt64), .out_rd(out_rd64),
    .out_imm_sext(out_imm_sext64), .out_imm_zext(out_imm_zext64),
    .out_jump_target(out_jump_target64), .out_class(out_class64), .count(count64)
`ifdef DECODE_BUFFER_ILLEGAL_EN
    , .out_illegal(out_illegal64)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_class(input logic [5:0] op);
    if (op == 6'h00)                          return 3'd0;
    if (op >= 6'h08 && op <= 6'h0F)           return 3'd1;
    if (op >= 6'h20 && op <= 6'h25)           return 3'd2;
    if (op >= 6'h28 && op <= 6'h2B)           return 3'd3;
    if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07)) return 3'd4;
    if (op == 6'h02 || op == 6'h03)           return 3'd5;
    return 3'd6;
  endfunction

  function automatic logic [31:0] exp_jump(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

  // Checks every output of both instances against the queue model.
  task automatic compare_all();
    int   n;
    ent_t h;
    logic ev, er;
    n  = q.size();
    ev = (n != 0) && !flush;
    er = (n != DEPTH) && !flush;
    chk("count", count, n);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    chk("count64", count64, n);
    chk("out_valid64", out_valid64, ev);
    chk("in_ready64", in_ready64, er);
    if (n != 0) begin
      h = q[0];
      chk("out_pc", out_pc, h.pc);
      chk("out_op", out_op, h.instr[31:26]);
      chk("out_func", out_func, h.instr[5:0]);
      chk("out_rs", out_rs, h.instr[25:21]);
      chk("out_rt", out_rt, h.instr[20:16]);
      chk("out_rd", out_rd, h.instr[15:11]);
      chk("imm_sext", out_imm_sext, {{16{h.instr[15]}}, h.instr[15:0]});
      chk("imm_zext", out_imm_zext, {16'h0, h.instr[15:0]});
      chk("jump", out_jump_target, exp_jump(h.instr, h.pc));
      chk("class", out_class, exp_class(h.instr[31:26]));
      chk("out_pc64", out_pc64, h.pc);
      chk("fields64", {out_op64, out_rs64, out_rt64, out_rd64, out_func64, out_class64},
          {h.instr[31:11], h.instr[5:0], exp_class(h.instr[31:26])});
      chk("imm_sext64", out_imm_sext64, {{48{h.instr[15]}}, h.instr[15:0]});
      chk("imm_zext64", out_imm_zext64, {48'h0, h.instr[15:0]});
      chk("jump64", out_jump_target64, exp_jump(h.instr, h.pc));
`ifdef DECODE_BUFFER_ILLEGAL_EN
      begin
        logic il;
        il = (ev && exp_class(h.instr[31:26]) == 3'd6) ||
             (h.instr[31:26] == 6'h00 && !(h.instr[5:0] inside
               {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                [6'h10:6'h13], [6'h18:6'h1B], [6'h20:6'h27], 6'h2A, 6'h2B}));
        chk("illegal", out_illegal, il);
        chk("illegal64", out_illegal64, il);
      end
`endif
    end
  endtask

  task automatic model_update();
    logic do_push, do_pop;
    if (!reset || flush) begin
      q.delete();
    end else begin
      do_pop  = out_ready && (q.size() != 0);
      do_push = in_valid && (q.size() != DEPTH);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{instr: in_instr, pc: in_pc});
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // lw $3, 16($2)
    push_one(32'h8C43_0010, 32'h0040_0000);
    chk("lw_valid", out_valid, 1);
    chk("lw_class", out_class, 2);
    chk("lw_rs", out_rs, 2);
    chk("lw_rt", out_rt, 3);
    chk("lw_sext", out_imm_sext, 32'h10);
    chk("lw_count", count, 1);
    pop_one();

    // addiu $2, $0, -1
    push_one(32'h2402_FFFF, 32'h0040_0004);
    chk("addiu_sext", out_imm_sext, 32'hFFFF_FFFF);
    chk("addiu_zext", out_imm_zext, 32'h0000_FFFF);
    chk("addiu_class", out_class, 1);
    chk("addiu_sext64", out_imm_sext64, 64'hFFFF_FFFF_FFFF_FFFF);
    pop_one();

    // j with pc+4 crossing into region 2; index 0x010000A shifts to 0x0400028
    push_one(32'h0810_000A, 32'h1FFF_FFFC);
    chk("j_target", out_jump_target, 32'h2040_0028);
    chk("j_class", out_class, 5);
    pop_one();

    for (int i = 0; i < 5; i++) begin
      push_one(32'h0000_0020 | (i << 11), 32'h0000_1000 + 32'(i * 4));
      if (i == 3) begin
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 4);
      end
    end
    chk("held_count", count, 4);
    chk("held_head_pc", out_pc, 32'h0000_1000);

    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = 32'h2000_0000 | 32'(i);
      in_pc    = 32'h0000_2000 + 32'(i * 4);
      step();
    end
    chk("wrap_count", count, 3);
    in_valid = 1'b0; out_ready = 1'b0;

    while (q.size() != DEPTH) push_one($urandom, $urandom & 32'hFFFF_FFFC);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);

`ifdef DECODE_BUFFER_ILLEGAL_EN
    push_one(32'hFC00_0000, 32'h0);
    chk("ill_op3f", out_illegal, 1);
    pop_one();
    push_one(32'h0000_0001, 32'h4);
    chk("ill_func01", out_illegal, 1);
    pop_one();
    push_one(32'h0022_1821, 32'h8);
    chk("ill_addu", out_illegal, 0);
    pop_one();
`endif

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(99) != 0);
      flush     = ($urandom_range(24) == 0);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      in_instr  = $urandom;
      in_pc     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
